// File: rtl/tank_pkg.sv
// Shared types and constants for the player tank and its downstream consumers
// (color_mapper sprite selection, future projectile/enemy blocks).
package tank_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'b001,
    DIR_RIGHT = 3'b010,
    DIR_LEFT  = 3'b011,
    DIR_DOWN  = 3'b100
  } dir_t;

  typedef enum logic {
    FIRE_READY   = 1'b0,
    FIRE_COOLING = 1'b1
  } fire_state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam int TANK_W = 32;
  localparam int TANK_H = 32;

endpackage

// File: rtl/tank_controller_if.sv
// Keyboard/pixel inputs and tank state outputs of tank_controller, plus
// debug visibility of the fire FSM state and cooldown counter.
interface tank_controller_if;
  import tank_pkg::*;

  logic [7:0]  keycode;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        is_tank;
  logic [9:0]  tankX;
  logic [9:0]  tankY;
  dir_t        tank_dir;
  logic        fire;
  fire_state_t fire_state;
  logic [5:0]  cooldown;

  // No valid/ready here: keycode is a level sampled on each frame tick, and
  // every output is a level except fire, a single-Clk pulse.
  modport master (
    output keycode, DrawX, DrawY,
    input  is_tank, tankX, tankY, tank_dir, fire, fire_state, cooldown
  );

  modport slave (
    input  keycode, DrawX, DrawY,
    output is_tank, tankX, tankY, tank_dir, fire, fire_state, cooldown
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous frame_clk into the Clk domain and emits a one-Clk
// pulse per frame_clk rising edge.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic       sync1;
  logic       sync2;
  logic       delay;
  logic [1:0] warm;
  logic       armed;

  // armed only sets once a genuinely low frame_clk has been seen after reset,
  // so a frame_clk already high at release cannot fake a rising edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      delay <= 1'b0;
      warm  <= 2'b00;
      armed <= 1'b0;
    end else begin
      sync1 <= frame_clk;
      sync2 <= sync1;
      delay <= sync2;
      warm  <= {warm[0], 1'b1};
      if (warm[1] && !sync2) armed <= 1'b1;
    end
  end

  assign frame_tick = sync2 & ~delay & armed;

endmodule

// File: rtl/tank_controller.sv
// Player tank position, facing and fire cooldown, updated once per video
// frame from the held keycode; is_tank is a same-cycle box test.
module tank_controller
  import tank_pkg::*;
#(
  parameter logic [9:0] START_X  = 10'd304,
  parameter logic [9:0] START_Y  = 10'd224,
  parameter logic [9:0] STEP     = 10'd2,
  parameter logic [9:0] SCREEN_W = 10'd640,
  parameter logic [9:0] SCREEN_H = 10'd480,
  parameter logic [5:0] COOLDOWN = 6'd30
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  tank_controller_if.slave  bus
);

  localparam logic [10:0] STEP_W = {1'b0, STEP};
  localparam logic [10:0] X_MAX  = {1'b0, SCREEN_W} - 11'(TANK_W);
  localparam logic [10:0] Y_MAX  = {1'b0, SCREEN_H} - 11'(TANK_H);

  logic        frame_tick;
  logic [10:0] tank_x;
  logic [10:0] tank_y;
  dir_t        tank_dir;
  logic        fire;
  fire_state_t state;
  logic [5:0]  cooldown;

  logic [10:0] x_nxt;
  logic [10:0] y_nxt;
  dir_t        dir_nxt;
  logic [10:0] draw_x;
  logic [10:0] draw_y;

  frame_tick_gen u_frame_tick_gen (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  // Positions are held in 11 bits so step arithmetic cannot wrap; the
  // clamps keep bit 10 at zero.
  always_comb begin
    x_nxt   = tank_x;
    y_nxt   = tank_y;
    dir_nxt = tank_dir;
    case (bus.keycode)
      KEY_W: begin
        dir_nxt = DIR_UP;
        y_nxt   = (tank_y < STEP_W) ? 11'd0 : tank_y - STEP_W;
      end
      KEY_S: begin
        dir_nxt = DIR_DOWN;
        y_nxt   = (tank_y + STEP_W > Y_MAX) ? Y_MAX : tank_y + STEP_W;
      end
      KEY_A: begin
        dir_nxt = DIR_LEFT;
        x_nxt   = (tank_x < STEP_W) ? 11'd0 : tank_x - STEP_W;
      end
      KEY_D: begin
        dir_nxt = DIR_RIGHT;
        x_nxt   = (tank_x + STEP_W > X_MAX) ? X_MAX : tank_x + STEP_W;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tank_x   <= {1'b0, START_X};
      tank_y   <= {1'b0, START_Y};
      tank_dir <= DIR_UP;
      fire     <= 1'b0;
      cooldown <= 6'd0;
      state    <= FIRE_READY;
    end else begin
      fire <= 1'b0;
      if (frame_tick) begin
        tank_x   <= x_nxt;
        tank_y   <= y_nxt;
        tank_dir <= dir_nxt;
        case (state)
          FIRE_READY: begin
            if (bus.keycode == KEY_SPACE) begin
              fire     <= 1'b1;
              cooldown <= COOLDOWN - 6'd1;
              state    <= FIRE_COOLING;
            end
          end
          FIRE_COOLING: begin
            if (cooldown == 6'd0) state <= FIRE_READY;
            else                  cooldown <= cooldown - 6'd1;
          end
          default: state <= FIRE_READY;
        endcase
      end
    end
  end

  assign draw_x = {1'b0, bus.DrawX};
  assign draw_y = {1'b0, bus.DrawY};

  // Unregistered on purpose: color_mapper derives its sprite address from
  // the same cycle's position.
  assign bus.is_tank = (draw_x >= tank_x) && (draw_x < tank_x + 11'(TANK_W)) &&
                       (draw_y >= tank_y) && (draw_y < tank_y + 11'(TANK_H));

  assign bus.tankX      = tank_x[9:0];
  assign bus.tankY      = tank_y[9:0];
  assign bus.tank_dir   = tank_dir;
  assign bus.fire       = fire;
  assign bus.fire_state = state;
  assign bus.cooldown   = cooldown;

endmodule

// File: tb/tb_tank_controller.sv
// Bench for tank_controller: hand-computed vector table, scoreboarded frame
// ticks, plus fire cadence, edge clamp and asynchronous reset sequences.
module tb_tank_controller;
  import tank_pkg::*;

  localparam int W = 23;

  logic clk;
  logic rst;
  logic frame_clk;

  tank_controller_if bus ();
  tank_controller_if bus2 ();

  tank_controller dut (
    .Clk       (clk),
    .Reset     (rst),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  tank_controller #(.START_X(10'd1)) dut2 (
    .Clk       (clk),
    .Reset     (rst),
    .frame_clk (frame_clk),
    .bus       (bus2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int cur_x;
  int cur_y;
  logic [2:0] cur_dir;

  typedef struct {
    logic [7:0] kc;
    int         ex;
    int         ey;
    logic [2:0] ed;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int x, input int y, input logic [2:0] d);
    return {10'(x), 10'(y), d};
  endfunction

  function automatic logic [W-1:0] dut_state();
    return {bus.tankX, bus.tankY, 3'(bus.tank_dir)};
  endfunction

  // Spec-level movement model used for the long loops.
  function automatic logic [W-1:0] model(input logic [7:0] kc, input int x, input int y,
                                         input logic [2:0] d);
    int nx = x;
    int ny = y;
    logic [2:0] nd = d;
    case (kc)
      8'h1A: begin nd = 3'b001; ny = (y < 2) ? 0 : y - 2; end
      8'h16: begin nd = 3'b100; ny = (y + 2 > 448) ? 448 : y + 2; end
      8'h04: begin nd = 3'b011; nx = (x < 2) ? 0 : x - 2; end
      8'h07: begin nd = 3'b010; nx = (x + 2 > 608) ? 608 : x + 2; end
      default: ;
    endcase
    return pack(nx, ny, nd);
  endfunction

  // One frame: raise frame_clk, confirm no change on edges 1-2, change on
  // edge 3, then probe the is_tank box around the expected position.
  task automatic do_tick(input logic [7:0] kc, input int ex, input int ey,
                         input logic [2:0] ed, output int fire_cycles);
    logic [W-1:0] exp;
    @(negedge clk);
    bus.keycode = kc;
    frame_clk = 1'b1;
    exp_q.push_back(pack(ex, ey, ed));
    fire_cycles = 0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      if (bus.fire) fire_cycles++;
      if (e < 3) begin
        check("hold_before_tick", 32'(dut_state()), 32'(pack(cur_x, cur_y, cur_dir)));
      end else if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        exp = exp_q.pop_front();
        check("tick_update", 32'(dut_state()), 32'(exp));
        cur_x = ex;
        cur_y = ey;
        cur_dir = ed;
      end
    end
    frame_clk = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.fire) fire_cycles++;
    end
    bus.DrawX = 10'(cur_x + 31); bus.DrawY = 10'(cur_y + 31); #1;
    check("is_tank_inner_corner", 32'(bus.is_tank), 32'd1);
    bus.DrawX = 10'(cur_x + 32); bus.DrawY = 10'(cur_y); #1;
    check("is_tank_right_edge", 32'(bus.is_tank), 32'd0);
    bus.DrawX = 10'(cur_x); bus.DrawY = 10'(cur_y + 32); #1;
    check("is_tank_bottom_edge", 32'(bus.is_tank), 32'd0);
  endtask

  initial begin
    int fc;
    logic [W-1:0] e;

    vecs[0]  = '{8'h07, 306, 224, 3'b010};
    vecs[1]  = '{8'h07, 308, 224, 3'b010};
    vecs[2]  = '{8'h07, 310, 224, 3'b010};
    vecs[3]  = '{8'h05, 310, 224, 3'b010};
    vecs[4]  = '{8'h05, 310, 224, 3'b010};
    vecs[5]  = '{8'h05, 310, 224, 3'b010};
    vecs[6]  = '{8'h05, 310, 224, 3'b010};
    vecs[7]  = '{8'h00, 310, 224, 3'b010};
    vecs[8]  = '{8'h1A, 310, 222, 3'b001};
    vecs[9]  = '{8'h16, 310, 224, 3'b100};
    vecs[10] = '{8'h04, 308, 224, 3'b011};

    rst = 1'b1;
    frame_clk = 1'b0;
    bus.keycode = 8'h00;
    bus.DrawX = 10'd0;
    bus.DrawY = 10'd0;
    bus2.keycode = 8'h00;
    bus2.DrawX = 10'd0;
    bus2.DrawY = 10'd0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // reset state
    check("reset_x", 32'(bus.tankX), 32'd304);
    check("reset_y", 32'(bus.tankY), 32'd224);
    check("reset_dir", 32'(bus.tank_dir), 32'd1);
    check("reset_fire", 32'(bus.fire), 32'd0);
    check("reset_state", 32'(bus.fire_state), 32'(FIRE_READY));
    check("reset_cooldown", 32'(bus.cooldown), 32'd0);
    bus.DrawX = 10'd320; bus.DrawY = 10'd240; #1;
    check("reset_is_tank_in", 32'(bus.is_tank), 32'd1);
    bus.DrawX = 10'd336; #1;
    check("reset_is_tank_out", 32'(bus.is_tank), 32'd0);
    cur_x = 304; cur_y = 224; cur_dir = 3'b001;

    // table-driven moves
    for (int i = 0; i < 11; i++) begin
      do_tick(vecs[i].kc, vecs[i].ex, vecs[i].ey, vecs[i].ed, fc);
      check("table_no_fire", 32'(fc), 32'd0);
    end

    // hold down until the bottom clamp
    for (int i = 0; i < 200; i++) begin
      e = model(8'h16, cur_x, cur_y, cur_dir);
      do_tick(8'h16, int'(e[22:13]), int'(e[12:3]), e[2:0], fc);
    end
    check("bottom_clamp_y", 32'(bus.tankY), 32'd448);

    // held space: pulses on ticks 1, 32, 63 only, each one Clk wide
    for (int t = 1; t <= 65; t++) begin
      do_tick(8'h2C, cur_x, cur_y, cur_dir, fc);
      check("fire_pulse_cycles", 32'(fc), (t == 1 || t == 32 || t == 63) ? 32'd1 : 32'd0);
    end
    check("cooling_state", 32'(bus.fire_state), 32'(FIRE_COOLING));
    check("cooling_count", 32'(bus.cooldown), 32'd27);

    // asynchronous reset mid-move
    for (int i = 0; i < 10; i++) begin
      e = model(8'h07, cur_x, cur_y, cur_dir);
      do_tick(8'h07, int'(e[22:13]), int'(e[12:3]), e[2:0], fc);
    end
    check("pre_reset_x", 32'(bus.tankX), 32'd328);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_reset_x", 32'(bus.tankX), 32'd304);
    check("async_reset_y", 32'(bus.tankY), 32'd224);
    check("async_reset_dir", 32'(bus.tank_dir), 32'd1);
    check("async_reset_cooldown", 32'(bus.cooldown), 32'd0);
    check("async_reset_state", 32'(bus.fire_state), 32'(FIRE_READY));
    frame_clk = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cur_x = 304; cur_y = 224; cur_dir = 3'b001;
    repeat (6) @(posedge clk);
    #1;
    check("no_tick_high_at_release", 32'(dut_state()), 32'(pack(304, 224, 3'b001)));
    @(negedge clk);
    frame_clk = 1'b0;
    repeat (4) @(posedge clk);
    do_tick(8'h07, 306, 224, 3'b010, fc);

    // left clamp on the START_X=1 instance
    bus2.keycode = 8'h04;
    do_tick(8'h00, cur_x, cur_y, cur_dir, fc);
    check("left_clamp_tick1_x", 32'(bus2.tankX), 32'd0);
    check("left_clamp_tick1_dir", 32'(bus2.tank_dir), 32'd3);
    do_tick(8'h00, cur_x, cur_y, cur_dir, fc);
    check("left_clamp_tick2_x", 32'(bus2.tankX), 32'd0);
    check("left_clamp_tick2_dir", 32'(bus2.tank_dir), 32'd3);
    check("left_clamp_y", 32'(bus2.tankY), 32'd224);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
